// File: rtl/alu_issue_pkg.sv
`default_nettype none
// ============================================================================
// alu_issue_pkg
// Shared constants for the ALU issue front end: opcode/funct values, ALU
// control codes (shared with the ALU) and instruction-field helpers.
// Revision: 1.0 - initial release
// ============================================================================
package alu_issue_pkg;

    localparam int c_N        = 32;
    localparam int c_CTR_SIZE = 4;

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_ADDIU = 6'h09;
    localparam logic [5:0] c_OP_SLTI  = 6'h0A;
    localparam logic [5:0] c_OP_SLTIU = 6'h0B;
    localparam logic [5:0] c_OP_ANDI  = 6'h0C;
    localparam logic [5:0] c_OP_ORI   = 6'h0D;
    localparam logic [5:0] c_OP_XORI  = 6'h0E;
    localparam logic [5:0] c_OP_LUI   = 6'h0F;

    localparam logic [5:0] c_FN_SLL  = 6'h00;
    localparam logic [5:0] c_FN_SRL  = 6'h02;
    localparam logic [5:0] c_FN_SRA  = 6'h03;
    localparam logic [5:0] c_FN_SLLV = 6'h04;
    localparam logic [5:0] c_FN_SRLV = 6'h06;
    localparam logic [5:0] c_FN_SRAV = 6'h07;
    localparam logic [5:0] c_FN_ADD  = 6'h20;
    localparam logic [5:0] c_FN_ADDU = 6'h21;
    localparam logic [5:0] c_FN_SUB  = 6'h22;
    localparam logic [5:0] c_FN_SUBU = 6'h23;
    localparam logic [5:0] c_FN_AND  = 6'h24;
    localparam logic [5:0] c_FN_OR   = 6'h25;
    localparam logic [5:0] c_FN_XOR  = 6'h26;
    localparam logic [5:0] c_FN_SLT  = 6'h2A;
    localparam logic [5:0] c_FN_SLTU = 6'h2B;

    // NOP passes ADin straight through to Result.
    typedef enum logic [c_CTR_SIZE-1:0] {
        ALU_ADD  = 4'd0,
        ALU_ADDU = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_SUBU = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_SLT  = 4'd7,
        ALU_SLTU = 4'd8,
        ALU_SLL  = 4'd9,
        ALU_SRL  = 4'd10,
        ALU_SRA  = 4'd11,
        ALU_NOP  = 4'd15
    } alu_ctr_e;

    function automatic logic [5:0] f_opcode(input logic [31:0] instr);
        return instr[31:26];
    endfunction

    function automatic logic [4:0] f_rt(input logic [31:0] instr);
        return instr[20:16];
    endfunction

    function automatic logic [4:0] f_rd(input logic [31:0] instr);
        return instr[15:11];
    endfunction

    function automatic logic [4:0] f_shamt(input logic [31:0] instr);
        return instr[10:6];
    endfunction

    function automatic logic [5:0] f_funct(input logic [31:0] instr);
        return instr[5:0];
    endfunction

    function automatic logic [15:0] f_imm(input logic [31:0] instr);
        return instr[15:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_decode.sv
`default_nettype none
// ============================================================================
// alu_decode
// Combinational decode of an instruction word into ALU control, operands,
// destination register, write enable, illegal flag and overflow-trap class.
// Revision: 1.0 - initial release
// ============================================================================
module alu_decode
    import alu_issue_pkg::*;
(
    input  logic [31:0]           instr,
    input  logic [c_N-1:0]        rs_val,
    input  logic [c_N-1:0]        rt_val,
    output logic [c_CTR_SIZE-1:0] alu_ctr,
    output logic [c_N-1:0]        a_din,
    output logic [c_N-1:0]        b_din,
    output logic [4:0]            dest,
    output logic                  wen,
    output logic                  illegal,
    output logic                  trap
);

    logic [15:0]    w_imm;
    logic [c_N-1:0] w_imm_sx;
    logic [c_N-1:0] w_imm_zx;
    logic [c_N-1:0] w_shamt_zx;
    logic [c_N-1:0] w_rs_sh_zx;
    logic           unused_rs_field;

    assign w_imm      = f_imm(instr);
    assign w_imm_sx   = {{16{w_imm[15]}}, w_imm};
    assign w_imm_zx   = {16'h0000, w_imm};
    assign w_shamt_zx = {27'd0, f_shamt(instr)};
    assign w_rs_sh_zx = {27'd0, rs_val[4:0]};
    // Operand values arrive already fetched, so the rs field is not needed.
    assign unused_rs_field = ^instr[25:21];

    always_comb begin
        alu_ctr = ALU_NOP;
        a_din   = '0;
        b_din   = '0;
        dest    = 5'd0;
        illegal = 1'b0;
        trap    = 1'b0;
        if (f_opcode(instr) == c_OP_RTYPE) begin
            dest  = f_rd(instr);
            a_din = rs_val;
            b_din = rt_val;
            case (f_funct(instr))
                c_FN_ADD:  begin alu_ctr = ALU_ADD; trap = 1'b1; end
                c_FN_ADDU: alu_ctr = ALU_ADDU;
                c_FN_SUB:  begin alu_ctr = ALU_SUB; trap = 1'b1; end
                c_FN_SUBU: alu_ctr = ALU_SUBU;
                c_FN_AND:  alu_ctr = ALU_AND;
                c_FN_OR:   alu_ctr = ALU_OR;
                c_FN_XOR:  alu_ctr = ALU_XOR;
                c_FN_SLT:  alu_ctr = ALU_SLT;
                c_FN_SLTU: alu_ctr = ALU_SLTU;
                c_FN_SLL:  begin alu_ctr = ALU_SLL; a_din = rt_val; b_din = w_shamt_zx; end
                c_FN_SRL:  begin alu_ctr = ALU_SRL; a_din = rt_val; b_din = w_shamt_zx; end
                c_FN_SRA:  begin alu_ctr = ALU_SRA; a_din = rt_val; b_din = w_shamt_zx; end
                c_FN_SLLV: begin alu_ctr = ALU_SLL; a_din = rt_val; b_din = w_rs_sh_zx; end
                c_FN_SRLV: begin alu_ctr = ALU_SRL; a_din = rt_val; b_din = w_rs_sh_zx; end
                c_FN_SRAV: begin alu_ctr = ALU_SRA; a_din = rt_val; b_din = w_rs_sh_zx; end
                default: begin
                    illegal = 1'b1;
                    dest    = 5'd0;
                    a_din   = '0;
                    b_din   = '0;
                end
            endcase
        end else begin
            dest  = f_rt(instr);
            a_din = rs_val;
            case (f_opcode(instr))
                c_OP_ADDI:  begin alu_ctr = ALU_ADD; b_din = w_imm_sx; trap = 1'b1; end
                c_OP_ADDIU: begin alu_ctr = ALU_ADDU; b_din = w_imm_sx; end
                c_OP_SLTI:  begin alu_ctr = ALU_SLT;  b_din = w_imm_sx; end
                c_OP_SLTIU: begin alu_ctr = ALU_SLTU; b_din = w_imm_sx; end
                c_OP_ANDI:  begin alu_ctr = ALU_AND;  b_din = w_imm_zx; end
                c_OP_ORI:   begin alu_ctr = ALU_OR;   b_din = w_imm_zx; end
                c_OP_XORI:  begin alu_ctr = ALU_XOR;  b_din = w_imm_zx; end
                c_OP_LUI:   a_din = {w_imm, 16'h0000};
                default: begin
                    illegal = 1'b1;
                    dest    = 5'd0;
                    a_din   = '0;
                end
            endcase
        end
    end

    assign wen = ~illegal & (dest != 5'd0);

endmodule
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
// alu_issue
// Two-stage issue/writeback front end for the behavioural ALU.
// Optional feature: ALU_TRAP_EN enables signed-overflow trapping.
// Revision: 1.0 - initial release
// ============================================================================
module alu_issue
    import alu_issue_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           instr,
    input  logic [c_N-1:0]        rs_val,
    input  logic [c_N-1:0]        rt_val,
    output logic [c_N-1:0]        ADin,
    output logic [c_N-1:0]        BDin,
    output logic [c_CTR_SIZE-1:0] ALU_ctr,
    output logic                  Carry_in,
    input  logic [c_N-1:0]        Result,
    input  logic                  Overflow,
    input  logic                  Carry_out,
    input  logic                  Zero,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [c_N-1:0]        out_result,
    output logic                  out_zero,
    output logic [4:0]            out_dest,
    output logic                  out_wen,
    output logic                  out_illegal,
    output logic                  out_ovf
);

    logic [c_CTR_SIZE-1:0] w_dec_ctr;
    logic [c_N-1:0]        w_dec_a;
    logic [c_N-1:0]        w_dec_b;
    logic [4:0]            w_dec_dest;
    logic                  w_dec_wen;
    logic                  w_dec_illegal;
    logic                  w_dec_trap;

    logic                  r_s1_valid;
    logic [4:0]            r_s1_dest;
    logic                  r_s1_wen;
    logic                  r_s1_illegal;
    logic                  r_s1_trap;

    logic                  w_s1_adv;
    logic                  w_s1_load;
    logic                  w_trap;

    alu_decode u_decode (
        .instr   (instr),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .alu_ctr (w_dec_ctr),
        .a_din   (w_dec_a),
        .b_din   (w_dec_b),
        .dest    (w_dec_dest),
        .wen     (w_dec_wen),
        .illegal (w_dec_illegal),
        .trap    (w_dec_trap)
    );

    assign w_s1_adv  = r_s1_valid & (~out_valid | out_ready);
    assign in_ready  = ~r_s1_valid | w_s1_adv;
    assign w_s1_load = in_valid & in_ready;
    assign Carry_in  = 1'b0;

`ifdef ALU_TRAP_EN
    logic unused_flags;
    assign w_trap       = r_s1_trap & Overflow;
    assign unused_flags = Carry_out;
`else
    logic unused_flags;
    assign w_trap       = 1'b0;
    assign unused_flags = Carry_out ^ Overflow ^ r_s1_trap;
`endif

    // Stage 1: the registered operands feed the ALU directly.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid   <= 1'b0;
            ADin         <= '0;
            BDin         <= '0;
            ALU_ctr      <= ALU_NOP;
            r_s1_dest    <= 5'd0;
            r_s1_wen     <= 1'b0;
            r_s1_illegal <= 1'b0;
            r_s1_trap    <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid   <= 1'b1;
            ADin         <= w_dec_a;
            BDin         <= w_dec_b;
            ALU_ctr      <= w_dec_ctr;
            r_s1_dest    <= w_dec_dest;
            r_s1_wen     <= w_dec_wen;
            r_s1_illegal <= w_dec_illegal;
            r_s1_trap    <= w_dec_trap;
        end else if (w_s1_adv) begin
            r_s1_valid   <= 1'b0;
        end
    end

    // Stage 2: writeback register, held while the writer stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_zero    <= 1'b0;
            out_dest    <= 5'd0;
            out_wen     <= 1'b0;
            out_illegal <= 1'b0;
            out_ovf     <= 1'b0;
        end else if (w_s1_adv) begin
            out_valid   <= 1'b1;
            out_result  <= Result;
            out_zero    <= Zero;
            out_dest    <= r_s1_dest;
            out_wen     <= r_s1_wen & ~w_trap;
            out_illegal <= r_s1_illegal;
            out_ovf     <= w_trap;
        end else if (out_valid & out_ready) begin
            out_valid   <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: doc/alu_issue.md
# alu_issue

Two-stage issue/writeback front end that drives the behavioural MIPS-like ALU (ADin/BDin/ALU_ctr/Carry_in). It accepts a raw 32-bit instruction plus register operands over a valid/ready handshake, decodes opcode/funct into the ALU control code and operands, registers them into the ALU, then captures Result/Zero/Overflow into a writeback register for the register-file writer. It sits between operand fetch and register writeback in the datapath.

## Interface
- n, 32, datapath width
- Ctr_size, 4, ALU_ctr width
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  instruction/operands valid
- in_ready  out  1  stage 1 can accept
- instr  in  32  MIPS instruction word
- rs_val, rt_val  in  n  register operands
- ADin, BDin  out  n  ALU operands (registered)
- ALU_ctr  out  Ctr_size  ALU op code (registered)
- Carry_in  out  1  constant 0
- Result  in  n  ALU result
- Overflow, Carry_out, Zero  in  1  ALU flags
- out_valid  out  1  writeback entry valid
- out_ready  in  1  writer accepts
- out_result  out  n  captured Result
- out_zero  out  1  captured Zero
- out_dest  out  5  destination register
- out_wen  out  1  write enable
- out_illegal  out  1  undecodable instruction
- out_ovf  out  1  signed-overflow trap

## Operation
- R-type (opcode 0), dest=rd: funct 0x20 ADD, 0x21 ADDU, 0x22 SUB, 0x23 SUBU, 0x24 AND, 0x25 OR, 0x26 XOR, 0x2A SLT, 0x2B SLTU, ADin=rs, BDin=rt. Shifts ADin=rt: 0x00 SLL, 0x02 SRL, 0x03 SRA with BDin=zero-extended shamt; 0x04 SLLV, 0x06 SRLV, 0x07 SRAV with BDin={0,rs[4:0]}.
- I-type, dest=rt, ADin=rs: 0x08 ADDI, 0x09 ADDIU, 0x0A SLTI, 0x0B SLTIU (sign-extended imm); 0x0C ANDI, 0x0D ORI, 0x0E XORI (zero-extended imm). 0x0F LUI: ALU_ctr=NOP, ADin={imm,16'b0}.
- Any other opcode/funct: ALU_ctr=NOP, ADin=0, out_illegal=1, out_wen=0.
- out_wen=0 whenever dest==0.
- Overflow from ADDU/SUBU (ALU carry) is ignored.
- Carry_out unused.

## Timing
- Stage 1 (issue reg: ADin, BDin, ALU_ctr, dest, wen, illegal, trap-class) loads when in_valid & in_ready.
- in_ready = ~s1_valid | s1_adv; s1_adv = s1_valid & (~out_valid | out_ready).
- On s1_adv, stage 2 captures Result, Zero, Overflow (combinational ALU path within one cycle).
- Latency: accepted at edge k -> ALU inputs valid cycle k+1 -> out_valid after edge k+2. Throughput 1/cycle with out_ready=1.
- Back-pressure: out_valid & ~out_ready holds all out_* stable; stage 1 holds; in_ready falls when both full. Simultaneous pop and push accepted same cycle.
- Reset (any time, discards in-flight entries): s1_valid=0, out_valid=0, ADin=BDin=0, ALU_ctr=NOP, Carry_in=0, all out_* = 0, in_ready=1 the cycle after reset deasserts.

## Configuration
- ALU_TRAP_EN defined: for ADD, SUB, ADDI with captured Overflow=1, out_ovf=1 and out_wen=0 (no writeback).
- Undefined: out_ovf tied 0; out_wen per decode only.

## Structure
- Shared package/header: opcode and funct constants, ALU_ctr codes (ADD…NOP, shared with the ALU), instruction-field slices.
- One combinational sub-module alu_decode: instr, rs_val, rt_val -> ALU_ctr, ADin, BDin, dest, wen, illegal, trap-class.

## Test plan
- ADD $3,$1,$2 with rs=10, rt=20 -> after 2 cycles out_result=30, out_dest=3, out_wen=1, out_zero=0.
- SLT rs=-13, rt=-12 -> out_result=1; SLTIU rs=5 imm=0xFFFF -> out_result=1.
- SLL rt=1 shamt=31 -> 0x80000000; SRA rt=0x80000000 shamt=4 -> 0xF8000000; LUI imm=0x1234 -> 0x12340000.
- ADD rs=0x7FFFFFFF, rt=1 -> with ALU_TRAP_EN out_ovf=1, out_wen=0; without it out_ovf=0, out_wen=1; ADDU same operands -> out_ovf=0.
- Back-to-back stream of 4 ops with out_ready low 3 cycles mid-stream -> in_ready=0 while both stages full, no loss/duplication, in-order results.
- Opcode 0x3F -> out_illegal=1, out_wen=0; reset asserted with both stages valid -> out_valid=0 next cycle, no stale output.
